hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-level forwarding and load-use stall logic of the five-stage pipeline.
- Tracks in-flight register writes across DEPTH post-decode slots, with configurable load latency and configurable flush depth.
- Decides stall for the decode-stage instruction and produces registered forward selects aligned with that instruction's arrival in EX.
- Sits beside the decode stage; drives the pipeline hold and bubble controls and the EX operand multiplexers.

Parameters:
REG_W, 5, register index width (NREG = 2^REG_W; register 0 never creates a hazard)
DEPTH, 3, post-decode slots; slot 0 = EX, slot DEPTH-1 = last forwarding stage (WB); legal range 2..8
LOAD_LAT, 1, extra cycles after EX before load data is forwardable; 0 <= LOAD_LAT <= DEPTH-2
KILL_SLOTS, 1, number of current slots (0..KILL_SLOTS-1) invalidated by flush; 0 <= KILL_SLOTS < DEPTH
FWD_W, 2, forward-select width; must satisfy 2^FWD_W >= DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_rs1, id_rs2  in  REG_W  source register indices
id_use_rs1, id_use_rs2  in  1  source is actually read
id_wr_en  in  1  instruction writes a register
id_wrreg  in  REG_W  destination register
id_is_load  in  1  result comes from data memory
flush  in  1  branch or jump redirect taken this cycle
stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX
ex_valid  out  1  registered; EX holds a real instruction
ex_fwd_rs1, ex_fwd_rs2  out  FWD_W  registered; 0 = register file, j = result held in slot j (1..DEPTH-1)
stall_cnt  out  32  registered count of stall cycles

Behaviour:
- State per slot k: v, wr, wrreg, ld. Reset clears all slots, ex_valid, both ex_fwd selects and stall_cnt to 0.
- Matching: slot k matches source s when all of the following hold: v, wr, wrreg == s, s != 0. Youngest match (lowest k) wins; older matches are ignored.
- Readiness: the producer in slot k will sit in slot k+1 when the consumer reaches EX.
  - Required minimum slot m = 1+LOAD_LAT if ld, else 1.
  - If k+1 < m, the source is hazardous.
  - Else if k+1 > DEPTH-1, the select is 0 (value already committed; the register file is write-before-read).
  - Else the select is k+1.
- stall = id_valid & ~flush & (hazard on rs1 with id_use_rs1, or hazard on rs2 with id_use_rs2). Unused sources are ignored.
- Each clock with no flush and no reset:
  - Slots shift, slot j <= slot j-1; the old slot DEPTH-1 retires.
  - Slot 0 <= the decode instruction if id_valid & ~stall, else a bubble (all fields 0).
  - ex_valid and ex_fwd_* load the computed values when a real instruction enters; otherwise ex_valid = 0 and ex_fwd_* = 0.
- Flush clock:
  - Decode instruction is discarded; slot 0 becomes a bubble.
  - Every j in 1..KILL_SLOTS becomes a bubble.
  - Every j > KILL_SLOTS <= slot j-1.
  - ex_valid = 0, ex_fwd_* = 0.
  - Flush overrides stall, and stall is forced 0 in that cycle.
- stall_cnt increments by 1 each clock stall = 1 and saturates at 0xFFFFFFFF.
- Reset mid-stall or mid-flush: all state is 0 the next cycle and stall deasserts immediately (no pending entries).
- Latency: a decision made in the decode cycle appears on ex_* one clock later. stall has 0-cycle latency.
- Both sources may receive different selects at once. rs1 == rs2 yields identical selects.

Test Plan (defaults DEPTH=3, LOAD_LAT=1, KILL_SLOTS=1):
1. add r1 then add r2,r1,r1 on consecutive cycles -> no stall; next cycle ex_fwd_rs1 = ex_fwd_rs2 = 1. Gap of 1 -> select 2. Gap of 2 -> select 0.
2. lw r1 followed by add r3,r1,r0 -> stall = 1 for exactly one cycle, ex_valid = 0 that cycle, then ex_fwd_rs1 = 2; stall_cnt = 1.
3. add r1, add r1, add r4,r1 (two writers of r1) -> youngest wins, ex_fwd_rs1 = 1. Writers to r0 are never forwarded: select 0, no stall.
4. lw r5 in slot 0 with flush asserted while a user of r5 sits in decode -> stall = 0. Next state: slot 0 and slot 1 are bubbles, old slot 1 moves to slot 2; ex_valid = 0.
5. Parameter sweep DEPTH=5, LOAD_LAT=2: load followed by its user at gap 0 -> 2 stall cycles, then select 3. At gap 1 -> 1 stall cycle. At gap 2 -> no stall, select 3.
6. Assert rst during a load-use stall -> next cycle all outputs 0, stall_cnt = 0, and the held decode instruction proceeds with select 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes over DEPTH post-decode slots,
// decides decode-stage stall and registers EX forward selects for the entering instruction.
module hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int KILL_SLOTS = 1,
    parameter int FWD_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wrreg,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [FWD_W-1:0] ex_fwd_rs1,
    output logic [FWD_W-1:0] ex_fwd_rs2,
    output logic [31:0]      stall_cnt
);
    logic [DEPTH-1:0] v_q, v_d, wr_q, wr_d, ld_q, ld_d;
    logic [REG_W-1:0] wrreg_q [DEPTH];
    logic [REG_W-1:0] wrreg_d [DEPTH];
    logic             ex_valid_q;
    logic [FWD_W-1:0] fwd1_q, fwd2_q, sel1, sel2;
    logic             haz1, haz2, enter;
    logic [31:0]      stall_cnt_q;

    // Scan oldest to youngest so the youngest matching producer overrides.
    function automatic logic [FWD_W:0] lookup(input logic [REG_W-1:0] s);
        logic             haz;
        logic [FWD_W-1:0] sel;
        int               m;
        haz = 1'b0;
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && wr_q[k] && wrreg_q[k] == s && s != '0) begin
                m   = ld_q[k] ? 1 + LOAD_LAT : 1;
                haz = (k + 1 < m);
                sel = (haz || k + 1 > DEPTH - 1) ? '0 : FWD_W'(k + 1);
            end
        end
        return {haz, sel};
    endfunction

    always_comb begin
        {haz1, sel1} = lookup(id_rs1);
        {haz2, sel2} = lookup(id_rs2);
        stall = id_valid & ~flush & ((haz1 & id_use_rs1) | (haz2 & id_use_rs2));
        enter = id_valid & ~stall & ~flush;
        v_d   = {v_q[DEPTH-2:0], enter};
        wr_d  = {wr_q[DEPTH-2:0], enter & id_wr_en};
        ld_d  = {ld_q[DEPTH-2:0], enter & id_is_load};
        wrreg_d[0] = enter ? id_wrreg : '0;
        for (int j = 1; j < DEPTH; j++) wrreg_d[j] = wrreg_q[j-1];
        // Flush squashes the wrong-path instructions that just moved into slots 1..KILL_SLOTS.
        if (flush) begin
            for (int j = 1; j <= KILL_SLOTS; j++) begin
                v_d[j]     = 1'b0;
                wr_d[j]    = 1'b0;
                ld_d[j]    = 1'b0;
                wrreg_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            wrreg_q     <= '{default: '0};
            ex_valid_q  <= 1'b0;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            wrreg_q     <= wrreg_d;
            ex_valid_q  <= enter;
            fwd1_q      <= enter ? sel1 : '0;
            fwd2_q      <= enter ? sel2 : '0;
            stall_cnt_q <= (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_fwd_rs1 = fwd1_q;
    assign ex_fwd_rs2 = fwd2_q;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table for default parameters plus hand sequences
// for reset-during-stall and a DEPTH=5/LOAD_LAT=2 instance sharing the same inputs.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_wr_en = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_wrreg = '0;
    logic        stall, ex_valid, stall5, ex_valid5;
    logic [1:0]  fwd1, fwd2;
    logic [2:0]  fwd1_5, fwd2_5;
    logic [31:0] cnt, cnt5;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_en(id_wr_en),
        .id_wrreg(id_wrreg), .id_is_load(id_is_load), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_fwd_rs1(fwd1), .ex_fwd_rs2(fwd2), .stall_cnt(cnt)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(2), .KILL_SLOTS(1), .FWD_W(3)) dut5 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_en(id_wr_en),
        .id_wrreg(id_wrreg), .id_is_load(id_is_load), .flush(flush), .stall(stall5),
        .ex_valid(ex_valid5), .ex_fwd_rs1(fwd1_5), .ex_fwd_rs2(fwd2_5), .stall_cnt(cnt5)
    );

    typedef struct {
        logic       val, u1, u2, wr, ld, fl, st, exv;
        logic [4:0] rs1, rs2, wd;
        logic [2:0] f1, f2;
    } vec_t;

    vec_t tab[$];
    vec_t big[$];

    function automatic vec_t mk(logic val, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic wr, logic [4:0] wd, logic ld, logic fl,
                                logic st, logic exv, logic [2:0] f1, logic [2:0] f2);
        vec_t t;
        t.val = val; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.wr = wr; t.wd = wd;
        t.ld = ld; t.fl = fl; t.st = st; t.exv = exv; t.f1 = f1; t.f2 = f2;
        return t;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0d expected=%0d", name, id, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input bit use5, input int id);
        @(negedge clk);
        id_valid = t.val; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
        id_wr_en = t.wr; id_wrreg = t.wd; id_is_load = t.ld; flush = t.fl;
        #1;
        chk("stall", id, use5 ? 32'(stall5) : 32'(stall), 32'(t.st));
        @(posedge clk);
        #1;
        chk("ex_valid", id, use5 ? 32'(ex_valid5) : 32'(ex_valid), 32'(t.exv));
        chk("ex_fwd_rs1", id, use5 ? 32'(fwd1_5) : 32'(fwd1), 32'(t.f1));
        chk("ex_fwd_rs2", id, use5 ? 32'(fwd2_5) : 32'(fwd2), 32'(t.f2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // add r1 / add r2,r1,r1 / gap-1 and gap-2 forwarding
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 1, 1, 1));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 7, 0, 1, 1, 1, 8, 0, 0, 0, 1, 2, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 9, 9, 1, 1, 1, 10, 0, 0, 0, 1, 0, 0));
        // load-use: one stall, then select 2
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 11, 0, 1, 1, 1, 3, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 11, 0, 1, 1, 1, 3, 0, 0, 0, 1, 2, 0));
        // youngest writer wins; r0 writers never forwarded
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 0, 1, 4, 0, 0, 0, 1, 1, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 1, 0, 0));
        // distinct selects on both sources; unused hazardous source ignored
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 12, 13, 1, 1, 1, 14, 0, 0, 0, 1, 2, 1));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 15, 1, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 15, 0, 0, 0, 1, 16, 0, 0, 0, 1, 0, 0));
        // flush over a load-use: no stall, load squashed
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 20, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 5, 0, 1, 0, 1, 6, 0, 1, 0, 0, 0, 0));
        tab.push_back(mk(1, 5, 0, 1, 0, 1, 6, 0, 0, 0, 1, 0, 0));
        // DEPTH=5, LOAD_LAT=2 load-use at gaps 0, 1, 2
        big.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        big.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        big.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        big.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 1, 3, 0));
        big.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0));
        big.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        big.push_back(mk(1, 0, 3, 0, 1, 1, 6, 0, 0, 1, 0, 0, 0));
        big.push_back(mk(1, 0, 3, 0, 1, 1, 6, 0, 0, 0, 1, 0, 3));
        big.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 0, 0));
        big.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        big.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        big.push_back(mk(1, 4, 4, 1, 1, 1, 7, 0, 0, 0, 1, 3, 3));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ex_valid", -1, 32'(ex_valid), 0);
        chk("reset_fwd", -1, {30'd0, fwd1 | fwd2}, 0);
        chk("reset_stall_cnt", -1, cnt, 0);
        for (int i = 0; i < tab.size(); i++) run(tab[i], 1'b0, i);
        chk("stall_cnt_table", -1, cnt, 1);

        // reset asserted while a load-use stall is pending
        run(mk(1, 0, 0, 0, 0, 1, 22, 1, 0, 0, 1, 0, 0), 1'b0, 100);
        @(negedge clk);
        id_valid = 1; id_rs1 = 22; id_rs2 = 0; id_use_rs1 = 1; id_use_rs2 = 0;
        id_wr_en = 1; id_wrreg = 23; id_is_load = 0; flush = 0;
        #1;
        chk("pre_reset_stall", 101, 32'(stall), 1);
        chk("pre_reset_cnt", 101, cnt, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ex_valid", 102, 32'(ex_valid), 0);
        chk("rst_fwd1", 102, 32'(fwd1), 0);
        chk("rst_stall_cnt", 102, cnt, 0);
        chk("rst_stall", 102, 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 103, 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("post_rst_ex_valid", 103, 32'(ex_valid), 1);
        chk("post_rst_fwd1", 103, 32'(fwd1), 0);
        chk("post_rst_cnt", 103, cnt, 0);

        do_reset();
        for (int i = 0; i < big.size(); i++) run(big[i], 1'b1, 200 + i);
        chk("stall_cnt_depth5", -1, cnt5, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
